// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared sample type and helpers for the fir filter chain
// Rev 1.0 : initial release
// ============================================================================
package fir_pkg;

   localparam int DATA_W = 16;

   typedef logic [DATA_W-1:0] sample_t;

   // Sticky flag update where a new set event beats a coincident clear.
   function automatic logic ovf_next(input logic cur, input logic set, input logic clr);
      return set ? 1'b1 : (clr ? 1'b0 : cur);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_decimator_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy count and zeroed empty output
// Rev 1.0 : initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic               w_pop;
   logic               w_push;

   assign empty  = (r_level == '0);
   assign full   = (r_level == c_LVL_W'(DEPTH));
   assign w_pop  = pop && !empty;
   // When full, a write may only land in the slot being vacated this cycle.
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign rdata = empty ? '0 : r_mem[r_rd_ptr];
   assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// fir_decimator : keeps every DECIM-th valid fir sample and buffers it
// Rev 1.0 : initial release
// ============================================================================
module fir_decimator #(
   parameter int DATA_W     = fir_pkg::DATA_W,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             y_in,
   input  logic                          y_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   input  logic                          clear_ovf
);

   import fir_pkg::*;

   localparam int c_PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [c_PH_W-1:0] r_phase;
   logic              r_overflow;
   logic              w_kept;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase <= '0;
      end else if (y_valid) begin
         r_phase <= (r_phase == c_PH_W'(DECIM - 1)) ? '0 : r_phase + 1'b1;
      end
   end

   assign w_kept    = y_valid && (r_phase == '0);
   assign out_valid = !w_empty;
   assign w_pop     = out_valid && out_ready;
   assign w_push    = w_kept && (!w_full || w_pop);
   assign w_drop    = w_kept && w_full && !w_pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= ovf_next(r_overflow, w_drop, clear_ovf);
      end
   end

   assign overflow = r_overflow;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (y_in),
      .rdata (out_data),
      .level (level),
      .full  (w_full),
      .empty (w_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_fir_decimator.sv
`default_nettype none
// ============================================================================
// tb_fir_decimator : scoreboard bench for DECIM=4 and DECIM=1 instances
// Rev 1.0 : initial release
// ============================================================================
module tb_fir_decimator;
   import fir_pkg::*;

   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       rst  [2];
   logic       vin  [2];
   logic       rdy  [2];
   logic       clr  [2];
   sample_t    yin  [2];
   sample_t    od   [2];
   logic       ovld [2];
   logic [3:0] lv   [2];
   logic       of   [2];

   sample_t q0[$];
   sample_t q1[$];
   int      m_lvl [2];
   int      m_n   [2];
   int      m_ovf [2];
   int      n_vec = 0;
   int      n_cmp = 0;
   int      n_err = 0;

   always #5 clock = ~clock;

   fir_decimator #(.DATA_W(16), .DECIM(4), .FIFO_DEPTH(DEPTH)) u_d4 (
      .clock(clock), .reset(rst[0]), .y_in(yin[0]), .y_valid(vin[0]),
      .out_data(od[0]), .out_valid(ovld[0]), .out_ready(rdy[0]),
      .level(lv[0]), .overflow(of[0]), .clear_ovf(clr[0]));

   fir_decimator #(.DATA_W(16), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_d1 (
      .clock(clock), .reset(rst[1]), .y_in(yin[1]), .y_valid(vin[1]),
      .out_data(od[1]), .out_valid(ovld[1]), .out_ready(rdy[1]),
      .level(lv[1]), .overflow(of[1]), .clear_ovf(clr[1]));

   function automatic int dec_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic chk(input string nm, input int i, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", nm, i, act, exp, $time);
      end
   endtask

   // Monitors: every accepted output word must be the oldest expected one.
   always @(posedge clock) begin
      if (!rst[0] && ovld[0] && rdy[0]) begin
         if (q0.size() == 0) chk("pop_unexpected", 0, int'(od[0]), -1);
         else                chk("pop_data", 0, int'(od[0]), int'(q0.pop_front()));
      end
   end

   always @(posedge clock) begin
      if (!rst[1] && ovld[1] && rdy[1]) begin
         if (q1.size() == 0) chk("pop_unexpected", 1, int'(od[1]), -1);
         else                chk("pop_data", 1, int'(od[1]), int'(q1.pop_front()));
      end
   end

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int head;
         if (i == 0) head = (q0.size() > 0) ? int'(q0[0]) : 0;
         else        head = (q1.size() > 0) ? int'(q1[0]) : 0;
         chk("level", i, int'(lv[i]), m_lvl[i]);
         chk("out_valid", i, int'(ovld[i]), int'(m_lvl[i] > 0));
         chk("overflow", i, int'(of[i]), m_ovf[i]);
         chk("out_data", i, int'(od[i]), (m_lvl[i] > 0) ? head : 0);
      end
   endtask

   // Reference model: kept = index of valid sample since reset is a multiple
   // of DECIM; buffer holds at most DEPTH words, a pop frees a slot same cycle.
   task automatic step();
      for (int i = 0; i < 2; i++) begin
         bit pop, kept, acc;
         if (rst[i]) begin
            if (i == 0) q0.delete(); else q1.delete();
            m_lvl[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
         end else begin
            pop  = (m_lvl[i] > 0) && rdy[i];
            kept = vin[i] && ((m_n[i] % dec_of(i)) == 0);
            if (vin[i]) m_n[i]++;
            acc = kept && ((m_lvl[i] < DEPTH) || pop);
            if (acc) begin
               if (i == 0) q0.push_back(yin[i]); else q1.push_back(yin[i]);
            end
            if (kept && !acc) m_ovf[i] = 1;
            else if (clr[i])  m_ovf[i] = 0;
            m_lvl[i] = m_lvl[i] + int'(acc) - int'(pop);
         end
      end
      @(posedge clock);
      n_vec++;
      @(negedge clock);
      check_all();
   endtask

   task automatic drive(input int i, input bit r, input bit v, input int y,
                        input bit rd, input bit c);
      rst[i] = r; vin[i] = v; yin[i] = 16'(y); rdy[i] = rd; clr[i] = c;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) drive(i, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_dut(input int i);
      drive(i, 1, 0, 0, 0, 0);
      step();
      drive(i, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) drive(i, 1, 0, 0, 0, 0);
      @(negedge clock);
      step();
      chk("reset_level", 0, int'(lv[0]), 0);
      chk("reset_valid", 1, int'(ovld[1]), 0);
      idle_all();

      // Decimate by 4 with a free-running consumer: 1, 5, 9 come out.
      for (int k = 1; k <= 12; k++) begin
         drive(0, 0, 1, k, 1, 0);
         step();
         if (k == 1) chk("t1_first_latency", 0, int'(od[0]), 1);
         if (k == 5) chk("t1_second", 0, int'(od[0]), 5);
      end
      chk("t1_overflow", 0, int'(of[0]), 0);

      // Phase advances only on valid samples: 10 and 14 are kept.
      reset_dut(0);
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, (k % 2) == 0, 10 + k / 2, 1, 0);
         step();
         if (k == 0) chk("t2_keep10", 0, int'(od[0]), 10);
         if (k == 8) chk("t2_keep14", 0, int'(od[0]), 14);
      end

      // DECIM=1: nine pushes into eight slots, then drain.
      idle_all();
      reset_dut(1);
      for (int k = 0; k < 9; k++) begin
         drive(1, 0, 1, 100 + k, 0, 0);
         step();
      end
      chk("t3_full_level", 1, int'(lv[1]), 8);
      chk("t3_overflow", 1, int'(of[1]), 1);
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0, 0, 1, 0);
         step();
      end
      chk("t3_drained", 1, int'(lv[1]), 0);

      // Full with a pop in the same cycle accepts the new sample.
      reset_dut(1);
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 1, 300 + k, 0, 0);
         step();
      end
      drive(1, 0, 1, 200, 1, 0);
      step();
      chk("t4_level", 1, int'(lv[1]), 8);
      chk("t4_overflow", 1, int'(of[1]), 0);
      for (int k = 0; k < 7; k++) begin
         drive(1, 0, 0, 0, 1, 0);
         step();
      end
      chk("t4_last", 1, int'(od[1]), 200);
      step();

      // Set beats clear on the sticky overflow flag.
      reset_dut(1);
      for (int k = 0; k < 9; k++) begin
         drive(1, 0, 1, 400 + k, 0, 0);
         step();
      end
      drive(1, 0, 1, 500, 0, 1);
      step();
      chk("t5_set_wins", 1, int'(of[1]), 1);
      drive(1, 0, 0, 0, 0, 1);
      step();
      chk("t5_cleared", 1, int'(of[1]), 0);
      idle_all();

      // Reset with five entries buffered, then phase restarts at zero.
      reset_dut(0);
      for (int k = 1; k <= 17; k++) begin
         drive(0, 0, 1, k, 0, 0);
         step();
      end
      chk("t6_level5", 0, int'(lv[0]), 5);
      reset_dut(0);
      chk("t6_rst_level", 0, int'(lv[0]), 0);
      chk("t6_rst_data", 0, int'(od[0]), 0);
      drive(0, 0, 1, 77, 0, 0);
      step();
      chk("t6_kept_after_rst", 0, int'(od[0]), 77);

      // Randomized traffic on both instances.
      for (int seg = 0; seg < 20; seg++) begin
         int rdy_pct = $urandom_range(0, 100);
         for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 2; i++) begin
               drive(i, $urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < 70,
                     int'($urandom_range(0, 65535)),
                     $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 99) < 5);
            end
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
